// File: rtl/definitions.sv
// Shared types and constants for the run sequencer.
package definitions;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_EXEC,
    S_LDWAIT,
    S_DONE
  } seq_state_t;

  localparam int unsigned MEM_LAT_MAX = 7;

endpackage

// File: rtl/run_sequencer_if.sv
// Bench/decoder handshake and commit-gate bundle of the run sequencer.
interface run_sequencer_if #(
  parameter int unsigned CYC_W = 16
);
  logic             Start;
  logic             Ack;
  logic             LoadInst;
  logic             RegWrEn;
  logic             MemWrEn;
  logic             PCReset;
  logic             PCEn;
  logic             RegWrGate;
  logic             MemWrGate;
  logic             Done;
  logic             TimedOut;
  logic [CYC_W-1:0] CycleCount;

  modport master (
    output Start, Ack, LoadInst, RegWrEn, MemWrEn,
    input  PCReset, PCEn, RegWrGate, MemWrGate, Done, TimedOut, CycleCount
  );

  modport slave (
    input  Start, Ack, LoadInst, RegWrEn, MemWrEn,
    output PCReset, PCEn, RegWrGate, MemWrGate, Done, TimedOut, CycleCount
  );
endinterface

// File: rtl/ld_wait_timer.sv
// 3-bit loadable down-counter that paces the load stall; last flags count==1.
module ld_wait_timer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic       en,
  input  logic [2:0] load_val,
  output logic       last
);
  logic [2:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != 3'd0)) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == 3'd1);
endmodule

// File: rtl/run_sequencer.sv
// Run controller: Start/Done handshake, PC hold, commit gating, load stall and timeout.
module run_sequencer
  import definitions::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CYC_W   = 16,
  parameter int unsigned TIMEOUT = 0
) (
  input logic             Clk,
  input logic             Reset,
  run_sequencer_if.slave  bus
);
  localparam int unsigned LAT     = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [2:0]  LAT_VAL = 3'(LAT);
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  seq_state_t       state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d, cyc_inc_c;
  logic             timed_out_q, timed_out_d;
  logic             commit_c, wait_load_c, wait_en_c, wait_last, timeout_hit_c;

  ld_wait_timer u_ld_wait_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (wait_load_c),
    .en       (wait_en_c),
    .load_val (LAT_VAL),
    .last     (wait_last)
  );

  // Saturating increment and budget comparison.
  assign cyc_inc_c     = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + CYC_W'(1);
  assign timeout_hit_c = (TIMEOUT != 0) && (cyc_q == CYC_W'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    timed_out_d = timed_out_q;
    commit_c    = 1'b0;
    wait_load_c = 1'b0;
    wait_en_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) state_d = S_ARM;
      end
      S_ARM: begin
        timed_out_d = 1'b0;
        if (!bus.Start) begin
          state_d = S_EXEC;
          cyc_d   = '0;
        end
      end
      S_EXEC: begin
        if (bus.Start) begin
          state_d     = S_ARM;
          timed_out_d = 1'b0;
        end else if (timeout_hit_c) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
        end else if (bus.Ack) begin
          state_d = S_DONE;
          cyc_d   = cyc_inc_c;
        end else if (bus.LoadInst && (LAT != 0)) begin
          state_d     = S_LDWAIT;
          wait_load_c = 1'b1;
          cyc_d       = cyc_inc_c;
        end else begin
          commit_c = 1'b1;
          cyc_d    = cyc_inc_c;
        end
      end
      S_LDWAIT: begin
        if (bus.Start) begin
          state_d     = S_ARM;
          timed_out_d = 1'b0;
        end else if (timeout_hit_c) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
        end else begin
          wait_en_c = 1'b1;
          cyc_d     = cyc_inc_c;
          if (wait_last) begin
            commit_c = 1'b1;
            state_d  = S_EXEC;
          end
        end
      end
      S_DONE: begin
        if (bus.Start) begin
          state_d     = S_ARM;
          timed_out_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      timed_out_q <= timed_out_d;
    end
  end

  // A reset cycle never commits, even if the old state was executing.
  assign bus.PCEn       = commit_c & ~Reset;
  assign bus.RegWrGate  = commit_c & ~Reset & bus.RegWrEn;
  assign bus.MemWrGate  = commit_c & ~Reset & bus.MemWrEn;
  assign bus.PCReset    = (state_q == S_IDLE) || (state_q == S_ARM);
  assign bus.Done       = (state_q == S_DONE);
  assign bus.TimedOut   = timed_out_q;
  assign bus.CycleCount = cyc_q;
endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Top-level run controller for the single-issue 9-bit core. Runs the Start/Done handshake with the bench and holds the PC in reset between runs. Gates the decoder's raw register-file and data-memory write enables so a write commits only when its instruction retires. Stalls the PC for a fixed number of cycles on loads, and stops on the decoder's Ack or on a cycle-budget timeout.

Parameters:
MEM_LAT, 2, extra wait cycles for a load instruction (0..7; 0 means loads retire in one cycle)
CYC_W, 16, width of the cycle counter
TIMEOUT, 0, cycle budget per run; 0 disables the timeout

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  bench request: high arms and holds; the falling edge starts the run
Ack  in  1  decoder "done w/ program" flag for the current instruction
LoadInst  in  1  decoder: current instruction is a load
RegWrEn  in  1  decoder raw reg_file write enable
MemWrEn  in  1  decoder raw data-memory write enable
PCReset  out  1  forces the program counter to 0
PCEn  out  1  PC update strobe (fetch unit applies its own branch/jump target selection)
RegWrGate  out  1  committed reg_file write enable
MemWrGate  out  1  committed data-memory write enable
Done  out  1  run finished
TimedOut  out  1  run ended by the budget, not by Ack
CycleCount  out  CYC_W  execute cycles in the current or last run

Behaviour:
- States: IDLE, ARM, EXEC, LDWAIT, DONE. One state register plus a 3-bit wait counter, CycleCount, and a TimedOut flag.
- Reset (synchronous, wins over everything) takes the block to IDLE. Reset values: PCReset=1, PCEn=0, RegWrGate=0, MemWrGate=0, Done=0, TimedOut=0, CycleCount=0, wait counter=0.
- Output timing:
  - PCReset, Done, TimedOut and CycleCount are registered or state-decoded.
  - PCEn, RegWrGate and MemWrGate are combinational from state and decoder inputs in the same cycle.
  - The three gates are 0 outside EXEC and LDWAIT.
- Commit: PCEn=1, RegWrGate=RegWrEn, MemWrGate=MemWrEn, all in the same cycle.
- IDLE: PCReset=1. Start=1 moves to ARM.
- ARM: PCReset=1, TimedOut cleared. Start=0 moves to EXEC and clears CycleCount to 0.
- EXEC, priority order:
  1. Start=1 aborts to ARM with no commit.
  2. If TIMEOUT!=0 and CycleCount==TIMEOUT, go to DONE with TimedOut=1. No commit, no increment.
  3. Ack=1 goes to DONE. No commit (Ack is never written back); CycleCount increments.
  4. LoadInst=1 with MEM_LAT>0 goes to LDWAIT and loads the wait counter with MEM_LAT. No commit; CycleCount increments.
  5. Otherwise commit, stay in EXEC, CycleCount increments.
- LDWAIT: the same abort and timeout checks apply first. The wait counter decrements each cycle and CycleCount increments. When the wait counter equals 1, commit and return to EXEC. Decoder inputs are held stable by the PC stall.
- Load latency: a load occupies exactly MEM_LAT+1 cycles. MEM_LAT=0 makes a load an ordinary one-cycle commit.
- DONE: Done=1, CycleCount and TimedOut hold. Start=1 moves to ARM, Done drops on the next cycle.
- CycleCount saturates at all-ones and never wraps.
- Ack and LoadInst high together: Ack wins, no wait is entered.
- Start held high through reset: IDLE, then ARM on the next cycle.
- Reset mid-run: no commit in the reset cycle, because gates are 0 when the state is forced.

Decomposition:
- Shared package "definitions" holds:
  - typedef enum logic[2:0] seq_state_t {S_IDLE, S_ARM, S_EXEC, S_LDWAIT, S_DONE}
  - the MEM_LAT_MAX=7 constant
- One natural sub-module, ld_wait_timer:
  - 3-bit loadable down-counter with load, enable and last (count==1) outputs
  - synchronous active-high Reset
- Everything else lives in run_sequencer.

Test Plan:
1. Reset; Start=1 for 3 cycles, then 0; present 4 ALU instructions (RegWrEn=1), then Ack -> PCEn and RegWrGate high exactly 4 cycles; Done=1 the cycle after Ack; CycleCount=5; TimedOut=0.
2. MEM_LAT=2, a load with RegWrEn=1 -> PCEn=0 in EXEC and the first LDWAIT cycle; commit on the 2nd LDWAIT cycle; CycleCount advances by 3.
3. Ack and LoadInst both 1 in EXEC -> DONE next cycle; no PCEn, RegWrGate or MemWrGate pulse; the wait counter is never loaded.
4. TIMEOUT=8, Ack never asserted -> 8 commits, then DONE with TimedOut=1, CycleCount=8. Restart via Start -> TimedOut clears in ARM.
5. Start raised in the first LDWAIT cycle -> ARM next cycle, PCReset=1, no gate pulses. Drop Start -> EXEC with CycleCount=0.
6. Reset asserted in DONE and in EXEC -> IDLE next cycle with all outputs at reset values (PCReset=1, Done=0, CycleCount=0).
